// File: rtl/fpadd_sched_if.sv
// Bundle of request, adder and response signals between two requesters,
// the fpadd_sched scheduler and a shared floating-point adder.
interface fpadd_sched_if #(
  parameter int W = 64
);
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic           add_start;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_done;
  logic [W-1:0]   add_result;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic           busy;

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b, add_done, add_result, rsp_ready,
    output req_ready, add_start, add_a, add_b, rsp_valid, rsp_data, rsp_err, busy
  );

  // Environment side: requesters plus the shared adder.
  modport master (
    output req_valid, req_a, req_b, add_done, add_result, rsp_ready,
    input  req_ready, add_start, add_a, add_b, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/fpadd_sched.sv
// Round-robin scheduler sharing one FP adder between two requesters.
// One operation in flight at a time; WAIT aborts after TMO cycles without
// add_done and returns an error response with zero data.
module fpadd_sched #(
  parameter int WEXP = 11,
  parameter int WSIG = 52,
  parameter int TMO  = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  fpadd_sched_if.slave  bus
);
  localparam int         W     = 1 + WEXP + WSIG;
  localparam logic [7:0] TMO_C = 8'(TMO);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e       state_q, state_d;
  logic         ptr_q, ptr_d;     // preferred requester
  logic         gnt_q, gnt_d;     // requester owning the in-flight op
  logic [7:0]   cnt_q, cnt_d;     // WAIT cycle counter
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] data_q, data_d;
  logic         err_q, err_d;

  logic         grant;
  logic [7:0]   cnt_inc;

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise a
    // path that skips the assignment infers a latch.
    state_d        = state_q;
    ptr_d          = ptr_q;
    gnt_d          = gnt_q;
    cnt_d          = cnt_q;
    a_d            = a_q;
    b_d            = b_q;
    data_d         = data_q;
    err_d          = err_q;
    bus.req_ready  = 2'b00;
    bus.add_start  = 1'b0;
    bus.rsp_valid  = 2'b00;
    grant          = bus.req_valid[ptr_q] ? ptr_q : ~ptr_q;
    cnt_inc        = cnt_q + 8'd1;

    case (state_q)
      IDLE: begin
        // reset_n gating keeps req_ready low for the whole reset pulse.
        if ((|bus.req_valid) && reset_n) begin
          bus.req_ready[grant] = 1'b1;
          gnt_d   = grant;
          ptr_d   = ~grant;
          a_d     = grant ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0];
          b_d     = grant ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        bus.add_start = 1'b1;
        cnt_d         = 8'd0;
        state_d       = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // A completion on the timeout cycle still wins over the abort.
        if (bus.add_done) begin
          data_d  = bus.add_result;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_inc == TMO_C) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid[gnt_q] = 1'b1;
        if (bus.rsp_ready[gnt_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: operand and result registers are reset too so add_a/add_b and
      // rsp_data are never X and rsp_data reads zero straight out of reset.
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      cnt_q   <= 8'd0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.add_a    = a_q;
  assign bus.add_b    = b_q;
  assign bus.rsp_data = data_q;
  assign bus.rsp_err  = err_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_fpadd_sched.sv
// Scoreboard bench for fpadd_sched: expected responses are queued when a
// request is accepted and compared when the scheduler presents them.
module tb_fpadd_sched;
  localparam int WEXP = 11;
  localparam int WSIG = 52;
  localparam int W    = 1 + WEXP + WSIG;
  localparam int TMO  = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fpadd_sched_if #(.W(W)) bus ();

  fpadd_sched #(.WEXP(WEXP), .WSIG(WSIG), .TMO(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic model_ptr = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a response, compares it with the scoreboard head, optionally
  // holds rsp_ready low for 'hold' cycles, then completes the handshake.
  task automatic wait_rsp(input int hold, output int waited);
    exp_t       e;
    logic [1:0] vbit;
    waited = 0;
    while (bus.rsp_valid == 2'b00 && waited < 20) begin
      tick();
      waited++;
    end
    n_total++;
    if (bus.rsp_valid == 2'b00) begin
      $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required nonzero", bus.rsp_valid, waited);
      return;
    end else n_pass++;
    n_total++;
    if (sb.size() == 0) begin
      $display("FAIL rsp_unexpected: rsp_valid=%b with empty scoreboard, required none", bus.rsp_valid);
      return;
    end else n_pass++;
    e    = sb.pop_front();
    vbit = 2'b01 << e.id;
    n_total++; if (bus.rsp_valid !== vbit) $display("FAIL rsp_valid: got %b required %b", bus.rsp_valid, vbit); else n_pass++;
    n_total++; if (bus.rsp_data !== e.data) $display("FAIL rsp_data: got %h required %h", bus.rsp_data, e.data); else n_pass++;
    n_total++; if (bus.rsp_err !== e.err) $display("FAIL rsp_err: got %b required %b", bus.rsp_err, e.err); else n_pass++;
    for (int i = 0; i < hold; i++) begin
      if (i == 3) begin
        bus.add_done   = 1'b1;
        bus.add_result = '1;
      end
      tick();
      bus.add_done   = 1'b0;
      bus.add_result = '0;
      n_total++; if (bus.rsp_valid !== vbit) $display("FAIL hold_valid: got %b required %b", bus.rsp_valid, vbit); else n_pass++;
      n_total++; if (bus.rsp_data !== e.data) $display("FAIL hold_data: got %h required %h", bus.rsp_data, e.data); else n_pass++;
      n_total++; if (bus.req_ready !== 2'b00) $display("FAIL hold_req_ready: got %b required 00", bus.req_ready); else n_pass++;
      n_total++; if (bus.add_start !== 1'b0) $display("FAIL hold_add_start: got %b required 0", bus.add_start); else n_pass++;
    end
    bus.rsp_ready = ~vbit;
    tick();
    bus.rsp_ready = 2'b00;
    n_total++; if (bus.rsp_valid !== vbit) $display("FAIL wrong_ready: got %b required %b", bus.rsp_valid, vbit); else n_pass++;
    bus.rsp_ready = vbit;
    tick();
    bus.rsp_ready = 2'b00;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL busy_after_rsp: got %b required 0", bus.busy); else n_pass++;
    n_total++; if (bus.rsp_valid !== 2'b00) $display("FAIL rsp_after_hs: got %b required 00", bus.rsp_valid); else n_pass++;
  endtask

  // One complete operation. done_delay = cycles from add_start to add_done,
  // 0 means the adder never answers. lat = acceptance to rsp_valid cycles.
  task automatic run_op(input logic [1:0] valid,
                        input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1,
                        input logic [W-1:0] r0, input logic [W-1:0] r1,
                        input int done_delay, input int hold, output int lat);
    logic         g;
    logic [1:0]   rdy;
    logic [W-1:0] ea, eb, er;
    exp_t         e;
    int           waited;
    bus.req_valid = valid;
    bus.req_a     = {a1, a0};
    bus.req_b     = {b1, b0};
    #1;
    g         = valid[model_ptr] ? model_ptr : ~model_ptr;
    model_ptr = ~g;
    rdy       = 2'b01 << g;
    ea        = g ? a1 : a0;
    eb        = g ? b1 : b0;
    er        = g ? r1 : r0;
    n_total++; if (bus.req_ready !== rdy) $display("FAIL req_ready: got %b required %b", bus.req_ready, rdy); else n_pass++;
    e.id   = g;
    e.data = (done_delay > 0) ? er : '0;
    e.err  = (done_delay == 0);
    sb.push_back(e);
    tick();
    lat = 1;
    n_total++; if (bus.add_start !== 1'b1) $display("FAIL add_start: got %b required 1", bus.add_start); else n_pass++;
    n_total++; if (bus.req_ready !== 2'b00) $display("FAIL issue_req_ready: got %b required 00", bus.req_ready); else n_pass++;
    n_total++; if (bus.add_a !== ea) $display("FAIL add_a: got %h required %h", bus.add_a, ea); else n_pass++;
    n_total++; if (bus.add_b !== eb) $display("FAIL add_b: got %h required %h", bus.add_b, eb); else n_pass++;
    n_total++; if (bus.busy !== 1'b1) $display("FAIL busy: got %b required 1", bus.busy); else n_pass++;
    if (done_delay > 0) begin
      tick();
      lat++;
      for (int i = 1; i < done_delay; i++) begin
        tick();
        lat++;
      end
      bus.add_done   = 1'b1;
      bus.add_result = er;
      n_total++; if (bus.add_a !== ea) $display("FAIL wait_add_a: got %h required %h", bus.add_a, ea); else n_pass++;
      n_total++; if (bus.add_b !== eb) $display("FAIL wait_add_b: got %h required %h", bus.add_b, eb); else n_pass++;
      n_total++; if (bus.add_start !== 1'b0) $display("FAIL wait_add_start: got %b required 0", bus.add_start); else n_pass++;
      tick();
      lat++;
      bus.add_done   = 1'b0;
      bus.add_result = '0;
    end
    wait_rsp(hold, waited);
    lat += waited;
  endtask

  task automatic test_reset();
    bus.req_valid = 2'b11;
    #1;
    n_total++; if (bus.req_ready !== 2'b00) $display("FAIL rst_req_ready: got %b required 00", bus.req_ready); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", bus.busy); else n_pass++;
    n_total++; if (bus.rsp_valid !== 2'b00) $display("FAIL rst_rsp_valid: got %b required 00", bus.rsp_valid); else n_pass++;
    n_total++; if (bus.add_start !== 1'b0) $display("FAIL rst_add_start: got %b required 0", bus.add_start); else n_pass++;
    n_total++; if (bus.rsp_data !== '0) $display("FAIL rst_rsp_data: got %h required 0", bus.rsp_data); else n_pass++;
    n_total++; if (bus.rsp_err !== 1'b0) $display("FAIL rst_rsp_err: got %b required 0", bus.rsp_err); else n_pass++;
    tick();
    bus.req_valid = 2'b00;
    reset_n       = 1'b1;
    model_ptr     = 1'b0;
    tick();
  endtask

  task automatic test_single_op();
    int lat;
    run_op(2'b01, 64'h3FF0000000000000, 64'h4000000000000000, 64'h0, 64'h0,
           64'h4008000000000000, 64'h0, 2, 0, lat);
    n_total++; if (lat != 4) $display("FAIL single_latency: got %0d required 4", lat); else n_pass++;
  endtask

  task automatic test_min_latency();
    int lat;
    run_op(2'b10, 64'h0, 64'h0, 64'h1111, 64'h2222, 64'h0, 64'h3333, 1, 0, lat);
    n_total++; if (lat != 3) $display("FAIL min_latency: got %0d required 3", lat); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    for (int k = 0; k < 4; k++) begin
      run_op(2'b11, 64'(k) + 64'hA0, 64'(k) + 64'hB0, 64'(k) + 64'hC0, 64'(k) + 64'hD0,
             64'(k) + 64'h1000, 64'(k) + 64'h2000, 1 + (k % 2), 0, lat);
    end
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_timeout();
    int lat;
    run_op(2'b01, 64'h5, 64'h6, 64'h0, 64'h0, 64'h77, 64'h0, 0, 0, lat);
    n_total++; if (lat != 2 + TMO) $display("FAIL timeout_latency: got %0d required %0d", lat, 2 + TMO); else n_pass++;
  endtask

  task automatic test_tie();
    int lat;
    run_op(2'b10, 64'h0, 64'h0, 64'h9, 64'hA, 64'h0, 64'hBEEF, TMO, 0, lat);
    n_total++; if (lat != 2 + TMO) $display("FAIL tie_latency: got %0d required %0d", lat, 2 + TMO); else n_pass++;
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(2'b11, 64'h12, 64'h34, 64'h56, 64'h78, 64'hCAFE, 64'hF00D, 2, 10, lat);
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset_in_wait();
    bus.req_valid = 2'b01;
    bus.req_a     = {64'h0, 64'h42};
    bus.req_b     = {64'h0, 64'h43};
    #1;
    n_total++; if (bus.req_ready !== 2'b01) $display("FAIL riw_accept: got %b required 01", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = 2'b00;
    tick();
    n_total++; if (bus.busy !== 1'b1) $display("FAIL riw_busy_wait: got %b required 1", bus.busy); else n_pass++;
    reset_n       = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL riw_busy_rst: got %b required 0", bus.busy); else n_pass++;
    n_total++; if (bus.req_ready !== 2'b00) $display("FAIL riw_req_ready: got %b required 00", bus.req_ready); else n_pass++;
    bus.req_valid = 2'b00;
    tick();
    reset_n        = 1'b1;
    model_ptr      = 1'b0;
    bus.add_done   = 1'b1;
    bus.add_result = 64'h1234;
    tick();
    bus.add_done   = 1'b0;
    bus.add_result = '0;
    n_total++; if (bus.rsp_valid !== 2'b00) $display("FAIL riw_rsp_valid: got %b required 00", bus.rsp_valid); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL riw_busy_after: got %b required 0", bus.busy); else n_pass++;
    begin
      int lat;
      run_op(2'b11, 64'h61, 64'h62, 64'h63, 64'h64, 64'h65, 64'h66, 1, 0, lat);
    end
    bus.req_valid = 2'b00;
    tick();
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.req_valid  = 2'b00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.add_done   = 1'b0;
    bus.add_result = '0;
    bus.rsp_ready  = 2'b00;
    tick();
    test_reset();
    test_single_op();
    test_min_latency();
    test_back_to_back();
    test_timeout();
    test_tie();
    test_backpressure();
    test_reset_in_wait();
    n_total++; if (sb.size() != 0) $display("FAIL sb_leftover: got %0d entries required 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fpadd_sched.md
FPADD_SCHED -- requirements
Module: fpadd_sched

Interface
REQ-001 Parameter: WEXP, 11, exponent field width.
REQ-002 Parameter: WSIG, 52, stored significand width; operand width W = 1+WEXP+WSIG (64 default).
REQ-003 Parameter: TMO, 255, max cycles waited for add_done before abort; 8-bit counter.
REQ-004 Port: clk  input  1  single clock, all state on rising edge.
REQ-005 Port: reset_n  input  1  asynchronous active-low reset.
REQ-006 Port: req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-007 Port: req_ready  output  2  per-requester request accept.
REQ-008 Port: req_a, req_b  input  2*W each  operand pairs, requester i at [i*W +: W].
REQ-009 Port: add_start  output  1  one-cycle start pulse to shared FP adder.
REQ-010 Port: add_a, add_b  output  W each  operands to adder, held stable from add_start until add_done or abort.
REQ-011 Port: add_done  input  1  one-cycle adder completion pulse.
REQ-012 Port: add_result  input  W  adder result, valid with add_done.
REQ-013 Port: rsp_valid  output  2  per-requester response valid.
REQ-014 Port: rsp_ready  input  2  per-requester response accept.
REQ-015 Port: rsp_data  output  W  result for the requester with rsp_valid set.
REQ-016 Port: rsp_err  output  1  response is a timeout abort; rsp_data = 0 then.
REQ-017 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-018 States: IDLE, ISSUE, WAIT, RESP; one operation in flight, adder never shared concurrently.
REQ-019 IDLE: if any req_valid, grant by round-robin pointer, assert req_ready for granted requester only (same cycle, combinational), latch operands and grant id, go ISSUE.
REQ-020 Round-robin: pointer names preferred requester; after a grant, pointer = other requester; single requester always granted.
REQ-021 Simultaneous req_valid=2'b11 SHALL be granted alternately, never same requester twice in a row.
REQ-022 req_ready SHALL be 0 in all states other than IDLE; a request is accepted only when req_valid & req_ready.
REQ-023 ISSUE: add_start=1 for exactly one cycle, timeout counter cleared, go WAIT.
REQ-024 WAIT: counter increments each cycle; on add_done capture add_result, rsp_err=0, go RESP.
REQ-025 WAIT: counter reaching TMO without add_done SHALL abort: rsp_data=0, rsp_err=1, go RESP.
REQ-026 add_done in IDLE, ISSUE or RESP SHALL be ignored (no state change).
REQ-027 add_done on the same cycle the counter reaches TMO SHALL take the result (done wins).
REQ-028 RESP: rsp_valid bit of granted requester held with stable rsp_data/rsp_err until rsp_ready of that bit; then go IDLE.
REQ-029 rsp_ready on the non-granted bit SHALL be ignored; rsp_valid is one-hot or zero.
REQ-030 Minimum latency: acceptance cycle N, add_start N+1, add_done earliest N+2, rsp_valid N+3.
REQ-031 Back-to-back: new request acceptable in the cycle after response handshake.
REQ-032 add_a/add_b SHALL hold the latched operands from ISSUE through WAIT; other states don't care.

Reset
REQ-033 reset_n low SHALL immediately force IDLE, pointer=0, counter=0, req_ready=2'b00 while low, add_start=0, rsp_valid=0, rsp_err=0, rsp_data=0, busy=0.
REQ-034 Reset mid-operation SHALL discard the in-flight operation without response; a late add_done after reset is ignored per REQ-026.
REQ-035 After reset release, requester 0 SHALL win the first simultaneous request.

Verification
REQ-036 Single op: requester 0, a=0x3FF0000000000000, b=0x4000000000000000, adder returns 0x4008000000000000 2 cycles after start -> rsp_valid=2'b01, rsp_data=0x4008000000000000, rsp_err=0, cycle N+4.
REQ-037 Contention: req_valid=2'b11 held for 4 ops -> grants 0,1,0,1; each rsp_valid only on the granted bit.
REQ-038 Timeout: TMO=4, adder never asserts add_done -> rsp_err=1, rsp_data=0 after 4 WAIT cycles, state returns IDLE after rsp_ready.
REQ-039 Backpressure: rsp_ready low 10 cycles -> rsp_valid/rsp_data stable, req_ready=0, no second add_start.
REQ-040 Reset in WAIT: reset_n low 1 cycle, then spurious add_done -> no rsp_valid, busy=0, next grant to requester 0.
REQ-041 Done/timeout tie: add_done on the cycle counter hits TMO -> rsp_err=0, rsp_data=add_result.
